icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Parametrised instruction-cache miss/refill controller that sits between the PC/fetch stage, the instruction cache and the unified memory port. On a hit it selects one instruction from the cache line. On a miss it stalls the PC and fetches a full line from memory as `BEATS` sequential reads, then writes the line into the cache and forwards the requested instruction in the write cycle (early restart). A `flush` input abandons an in-flight refill cleanly, which branch redirects need.

## Interface
- `ADDR_W`, 16: instruction address width, in units of `INSTR_W`.
- `INSTR_W`, 16: instruction width.
- `MEM_W`, 32: memory data width. Must be a power-of-two multiple of `INSTR_W`.
- `BEATS`, 2: memory reads per line. Power of two, ≥1. Derived values:
  - `LINE_W = MEM_W*BEATS`
  - `OFF = log2(LINE_W/INSTR_W)`
  - `MOFF = log2(MEM_W/INSTR_W)`
- `clk` in 1: the only clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_addr` in ADDR_W: fetch address.
- `hit` in 1: icache tag match for `pc_addr`.
- `flush` in 1: pipeline redirect; discard the current fetch or refill.
- `rd_data_icache` in LINE_W: line read from the icache.
- `re_icache` out 1: icache read enable.
- `we_icache` out 1: icache write enable, one cycle per completed refill.
- `wr_data_icache` out LINE_W: assembled line.
- `fill_addr` out ADDR_W-OFF: line index for the icache write.
- `re_mem` out 1: memory read request.
- `addr_mem` out ADDR_W-MOFF: memory word address.
- `rd_data_mem` in MEM_W: memory read data, valid with `rdy_mem`.
- `rdy_mem` in 1: single-cycle completion pulse.
- `instr` out INSTR_W: selected instruction.
- `instr_valid` out 1: `instr` is valid this cycle.
- `pc_stall` out 1: hold the PC.
- `refill_busy` out 1: high in FILL, DRAIN and WRITE.

## Operation
- Selection rule: `instr = src[pc_off*INSTR_W +: INSTR_W]`, where `pc_off = pc_addr[OFF-1:0]`. `src` is `rd_data_icache` in IDLE and the assembled line buffer in WRITE.
- Registers:
  - `state`
  - `base` (miss line index, ADDR_W-OFF bits)
  - `off` (latched `pc_off`)
  - `beat` counter (log2 BEATS bits; absent when BEATS=1)
  - `line` buffer (LINE_W)
- Address during FILL and DRAIN: `addr_mem = {base, beat}` when `BEATS>1`, otherwise `base`. `fill_addr = base`.
- IDLE:
  - `re_icache=1`.
  - `flush=1`: `instr_valid=0`, `pc_stall=0`, stay in IDLE.
  - `hit=1`: `instr_valid=1`, `pc_stall=0`.
  - `hit=0`:
    - Same cycle: `pc_stall=1`, `re_mem=1`, `addr_mem = {pc_addr[ADDR_W-1:OFF], 0}`.
    - Latch `base` and `off`, clear `beat`, next state FILL.
- FILL:
  - Outputs: `pc_stall=1`, `re_mem=1`, `addr_mem` held stable until `rdy_mem`.
  - On `rdy_mem`, write `line[beat*MEM_W +: MEM_W] <= rd_data_mem`.
    - If `beat==BEATS-1`, go to WRITE.
    - Otherwise `beat++`; the next request starts in the following cycle.
  - `flush` without `rdy_mem`: go to DRAIN.
  - `flush` together with `rdy_mem`: discard the beat and go to IDLE. Flush wins, even on the final beat.
- DRAIN:
  - `re_mem=1` with the same address until `rdy_mem`; memory cannot abort a request.
  - On `rdy_mem`, discard the data and go to IDLE.
  - `we_icache` is never asserted. `flush` is ignored.
- WRITE (exactly one cycle):
  - `we_icache=1` with `wr_data_icache=line`.
  - `instr` is selected from `line` using `off`. `instr_valid=~flush`.
  - `pc_stall=0`, `re_icache=0`; next state IDLE.
  - `flush` does not cancel the write.
- `rdy_mem` is ignored in IDLE and WRITE.
- Reset:
  - While `rst` is high, outputs are forced to: `pc_stall=1`, `re_mem=0`, `re_icache=0`, `we_icache=0`, `instr_valid=0`, `refill_busy=0`.
  - Next state is IDLE; `beat`, `base`, `off` and `line` are cleared.
  - Reset mid-refill drops the fill with no icache write. Memory shares `rst`, so no stale `rdy_mem` follows.

## Timing
- Hit: combinational. `instr` and `instr_valid` appear in the same cycle as `pc_addr`/`hit`.
- Miss penalty: let memory latency be L cycles from request to `rdy_mem`.
  - Each beat takes L+1 cycles, counted from its first `re_mem` cycle to the cycle after `rdy_mem`.
  - The WRITE cycle directly follows the final `rdy_mem` edge.
  - The instruction is delivered in WRITE; the next fetch resumes in IDLE the cycle after.
- `we_icache` is a pulse exactly one clock wide, once per refill.
- `wr_data_icache` and `fill_addr` are valid only while `we_icache` is high.

## Test plan
- Hit, default parameters:
  - Stimulus: `pc_addr=0x0042`, `hit=1`, `rd_data_icache=0x4444_3333_2222_1111`.
  - Response: `instr=0x3333`, `instr_valid=1`, `pc_stall=0`, `re_mem=0`.
- Miss, default parameters, L=3:
  - Stimulus: `pc_addr=0x0013`, `hit=0`.
  - Memory sequence: `addr_mem=0x0008` until `rdy_mem` with `0xBBBBAAAA`; then `addr_mem=0x0009` until `rdy_mem` with `0xDDDDCCCC`.
  - WRITE cycle: `we_icache=1`, `wr_data_icache=0xDDDDCCCC_BBBBAAAA`, `fill_addr=0x0004`, `instr=0xDDDD`, `instr_valid=1`.
  - Next cycle is IDLE.
- `flush` during FILL:
  - Stimulus: `flush` pulse one cycle into the beat-0 wait.
  - Response: `re_mem` stays high at `0x0008` until `rdy_mem`, then IDLE.
  - `we_icache` and `instr_valid` never assert.
- `flush` coincident with the final `rdy_mem`: IDLE next cycle, no write.
- Reset mid-refill:
  - Stimulus: `rst` after beat 0 completes.
  - Response: IDLE with reset outputs, no write. A following miss restarts at beat 0.
- BEATS=4, MEM_W=16:
  - Stimulus: miss at `0x0016`.
  - Response: `addr_mem` steps `0x0014`–`0x0017`; beats fill `line` from low to high.
  - `instr` is beat 2's data.
  - Spurious `rdy_mem` in IDLE beforehand has no effect.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// Memory read port between the icache refill controller and the unified memory.
// The controller drives the request side (master); memory returns data with a
// single-cycle rdy_mem pulse (slave).
interface icache_refill_ctrl_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int MEM_W   = 32
);
  localparam int MOFF = $clog2(MEM_W / INSTR_W);

  logic                   re_mem;
  logic [ADDR_W-MOFF-1:0] addr_mem;
  logic [MEM_W-1:0]       rd_data_mem;
  logic                   rdy_mem;

  modport master (
    output re_mem,
    output addr_mem,
    input  rd_data_mem,
    input  rdy_mem
  );

  modport slave (
    input  re_mem,
    input  addr_mem,
    output rd_data_mem,
    output rdy_mem
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill controller. Hits are served combinationally
// from the icache line. A miss stalls the PC, fetches the line as BEATS
// sequential memory reads, writes it into the icache in a single WRITE cycle
// and forwards the requested instruction in that same cycle. A flush abandons
// the refill; an outstanding memory read is drained because memory cannot
// abort a request.
module icache_refill_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int MEM_W   = 32,
  parameter int BEATS   = 2,
  localparam int LINE_W = MEM_W * BEATS,
  localparam int OFF    = $clog2(LINE_W / INSTR_W),
  localparam int MOFF   = $clog2(MEM_W / INSTR_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       pc_addr,
  input  logic                    hit,
  input  logic                    flush,
  input  logic [LINE_W-1:0]       rd_data_icache,
  output logic                    re_icache,
  output logic                    we_icache,
  output logic [LINE_W-1:0]       wr_data_icache,
  output logic [ADDR_W-OFF-1:0]   fill_addr,
  icache_refill_ctrl_if.master    mem,
  output logic [INSTR_W-1:0]      instr,
  output logic                    instr_valid,
  output logic                    pc_stall,
  output logic                    refill_busy
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, WRITE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_W-OFF-1:0]  base;
  logic [OFF-1:0]         off;
  logic [BW-1:0]          beat;
  logic [LINE_W-1:0]      line;

  logic [OFF-1:0]         pc_off;
  logic                   last_beat;
  logic [ADDR_W-MOFF-1:0] miss_word;
  logic [ADDR_W-MOFF-1:0] fill_word;

  assign pc_off    = pc_addr[OFF-1:0];
  assign last_beat = (beat == BW'(BEATS - 1));

  // First word of the missing line: line index with the beat field zeroed.
  assign miss_word = (ADDR_W-MOFF)'(pc_addr[ADDR_W-1:OFF]) << (OFF - MOFF);

  if (BEATS > 1) begin : g_multi_beat
    assign fill_word = {base, beat};
  end else begin : g_single_beat
    assign fill_word = base;
  end

  assign wr_data_icache = line;
  assign fill_addr      = base;

  // State register plus miss bookkeeping: latch the line/offset on a miss and
  // collect memory beats into the line buffer, lowest beat first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      off   <= '0;
      beat  <= '0;
      line  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (!flush && !hit) begin
            base <= pc_addr[ADDR_W-1:OFF];
            off  <= pc_off;
            beat <= '0;
          end
        end
        FILL: begin
          if (mem.rdy_mem && !flush) begin
            line[beat*MEM_W +: MEM_W] <= mem.rd_data_mem;
            if (!last_beat) begin
              beat <= beat + BW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode; reset overrides everything at the end.
  always_comb begin
    state_next   = state;
    re_icache    = 1'b0;
    we_icache    = 1'b0;
    mem.re_mem   = 1'b0;
    mem.addr_mem = fill_word;
    instr        = rd_data_icache[pc_off*INSTR_W +: INSTR_W];
    instr_valid  = 1'b0;
    pc_stall     = 1'b1;
    refill_busy  = (state != IDLE);

    unique case (state)
      IDLE: begin
        re_icache = 1'b1;
        pc_stall  = 1'b0;
        if (!flush) begin
          if (hit) begin
            instr_valid = 1'b1;
          end else begin
            pc_stall     = 1'b1;
            mem.re_mem   = 1'b1;
            mem.addr_mem = miss_word;
            state_next   = FILL;
          end
        end
      end
      FILL: begin
        mem.re_mem = 1'b1;
        if (mem.rdy_mem) begin
          if (flush) begin
            state_next = IDLE;
          end else if (last_beat) begin
            state_next = WRITE;
          end
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        mem.re_mem = 1'b1;
        if (mem.rdy_mem) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        we_icache   = 1'b1;
        instr       = line[off*INSTR_W +: INSTR_W];
        instr_valid = ~flush;
        pc_stall    = 1'b0;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (rst) begin
      pc_stall    = 1'b1;
      mem.re_mem  = 1'b0;
      re_icache   = 1'b0;
      we_icache   = 1'b0;
      instr_valid = 1'b0;
      refill_busy = 1'b0;
      state_next  = IDLE;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: instance 0 uses default parameters, instance 1
// uses BEATS=4, MEM_W=16. A line-level behavioural model predicts outputs
// every cycle; directed literal checks pin the model to hand-computed values.
module tb_icache_refill_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [15:0] pc_addr [2];
  logic        hit [2];
  logic        flush [2];
  logic [63:0] rdi [2];

  logic        re_icache_o [2];
  logic        we_o [2];
  logic [63:0] wr_o [2];
  logic [13:0] fill_o [2];
  logic [15:0] instr_o [2];
  logic        iv_o [2];
  logic        stall_o [2];
  logic        busy_o [2];
  logic        re_o [2];
  logic [31:0] addr_o [2];

  logic        rdy [2];
  logic [31:0] rdm [2];

  int n_checks = 0;
  int n_errors = 0;

  icache_refill_ctrl_if #(.ADDR_W(16), .INSTR_W(16), .MEM_W(32)) mem0 ();
  icache_refill_ctrl_if #(.ADDR_W(16), .INSTR_W(16), .MEM_W(16)) mem1 ();

  assign mem0.rdy_mem     = rdy[0];
  assign mem0.rd_data_mem = rdm[0];
  assign mem1.rdy_mem     = rdy[1];
  assign mem1.rd_data_mem = rdm[1][15:0];
  assign re_o[0]   = mem0.re_mem;
  assign re_o[1]   = mem1.re_mem;
  assign addr_o[0] = 32'(mem0.addr_mem);
  assign addr_o[1] = 32'(mem1.addr_mem);

  icache_refill_ctrl #(.ADDR_W(16), .INSTR_W(16), .MEM_W(32), .BEATS(2)) dut0 (
    .clk(clk), .rst(rst), .pc_addr(pc_addr[0]), .hit(hit[0]), .flush(flush[0]),
    .rd_data_icache(rdi[0]), .re_icache(re_icache_o[0]), .we_icache(we_o[0]),
    .wr_data_icache(wr_o[0]), .fill_addr(fill_o[0]), .mem(mem0),
    .instr(instr_o[0]), .instr_valid(iv_o[0]), .pc_stall(stall_o[0]),
    .refill_busy(busy_o[0])
  );

  icache_refill_ctrl #(.ADDR_W(16), .INSTR_W(16), .MEM_W(16), .BEATS(4)) dut1 (
    .clk(clk), .rst(rst), .pc_addr(pc_addr[1]), .hit(hit[1]), .flush(flush[1]),
    .rd_data_icache(rdi[1]), .re_icache(re_icache_o[1]), .we_icache(we_o[1]),
    .wr_data_icache(wr_o[1]), .fill_addr(fill_o[1]), .mem(mem1),
    .instr(instr_o[1]), .instr_valid(iv_o[1]), .pc_stall(stall_o[1]),
    .refill_busy(busy_o[1])
  );

  task automatic checkOutput(input string name, input int k,
                             input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [15:0] pc, input logic h,
                               input logic fl, input logic [63:0] line);
    pc_addr[k] = pc;
    hit[k]     = h;
    flush[k]   = fl;
    rdi[k]     = line;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Memory contents seen by each instance.
  function automatic logic [31:0] mem_word(input int k, input logic [31:0] a);
    if (k == 0) begin
      if (a == 32'h8) return 32'hBBBB_AAAA;
      if (a == 32'h9) return 32'hDDDD_CCCC;
      return 32'hC0DE_0000 | a;
    end
    return 32'h0000_B000 + a;
  endfunction

  // Memory responder: rdy_mem arrives lat cycles after the first re_mem cycle.
  int lat [2];
  int waited [2];
  bit spur [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      rdy[k] = 1'b0;
      rdm[k] = '0;
      waited[k] = 0;
      spur[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        rdy[k] = 1'b0;
        rdm[k] = '0;
        if (rst) begin
          waited[k] = 0;
        end else if (spur[k]) begin
          rdy[k]  = 1'b1;
          rdm[k]  = 32'hDEAD_BEEF;
          spur[k] = 1'b0;
        end else if (re_o[k]) begin
          if (waited[k] == lat[k]) begin
            rdy[k]    = 1'b1;
            rdm[k]    = mem_word(k, addr_o[k]);
            waited[k] = 0;
          end else begin
            waited[k]++;
          end
        end
      end
    end
  end

  // Line-level model: a refill is either outstanding or not; it collects
  // words until the line is full, then is written once. A flush marks the
  // refill as abandoned so the next returning word just ends it.
  bit          pend [2];
  bit          drop [2];
  int          got [2];
  logic [63:0] line_m [2];
  int          base_m [2];
  int          off_m [2];
  int          nb [2];
  int          mw [2];
  logic [63:0] mask;
  int          pc_word;

  initial begin
    nb[0] = 2;  mw[0] = 32;
    nb[1] = 4;  mw[1] = 16;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; drop[k] = 1'b0; got[k] = 0;
      line_m[k] = '0; base_m[k] = 0; off_m[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        pc_word = int'(pc_addr[k][1:0]);
        if (rst) begin
          checkOutput("rst_pc_stall", k, 64'(stall_o[k]), 64'd1);
          checkOutput("rst_re_mem", k, 64'(re_o[k]), 64'd0);
          checkOutput("rst_re_icache", k, 64'(re_icache_o[k]), 64'd0);
          checkOutput("rst_we_icache", k, 64'(we_o[k]), 64'd0);
          checkOutput("rst_instr_valid", k, 64'(iv_o[k]), 64'd0);
          checkOutput("rst_refill_busy", k, 64'(busy_o[k]), 64'd0);
          pend[k] = 1'b0;
        end else if (!pend[k]) begin
          checkOutput("idle_re_icache", k, 64'(re_icache_o[k]), 64'd1);
          checkOutput("idle_we_icache", k, 64'(we_o[k]), 64'd0);
          checkOutput("idle_busy", k, 64'(busy_o[k]), 64'd0);
          checkOutput("idle_valid", k, 64'(iv_o[k]), 64'(!flush[k] && hit[k]));
          checkOutput("idle_stall", k, 64'(stall_o[k]), 64'(!flush[k] && !hit[k]));
          checkOutput("idle_re_mem", k, 64'(re_o[k]), 64'(!flush[k] && !hit[k]));
          if (!flush[k] && hit[k])
            checkOutput("hit_instr", k, 64'(instr_o[k]), (rdi[k] >> (16 * pc_word)) & 64'hFFFF);
          if (!flush[k] && !hit[k]) begin
            checkOutput("miss_addr", k, 64'(addr_o[k]), 64'((int'(pc_addr[k]) / 4) * nb[k]));
            pend[k] = 1'b1; drop[k] = 1'b0; got[k] = 0; line_m[k] = '0;
            base_m[k] = int'(pc_addr[k]) / 4;
            off_m[k] = pc_word;
          end
        end else if (got[k] < nb[k]) begin
          checkOutput("fetch_re_mem", k, 64'(re_o[k]), 64'd1);
          checkOutput("fetch_addr", k, 64'(addr_o[k]), 64'(base_m[k] * nb[k] + got[k]));
          checkOutput("fetch_busy", k, 64'(busy_o[k]), 64'd1);
          checkOutput("fetch_we", k, 64'(we_o[k]), 64'd0);
          checkOutput("fetch_valid", k, 64'(iv_o[k]), 64'd0);
          checkOutput("fetch_re_icache", k, 64'(re_icache_o[k]), 64'd0);
          if (!drop[k])
            checkOutput("fetch_stall", k, 64'(stall_o[k]), 64'd1);
          if (rdy[k]) begin
            if (drop[k] || flush[k]) begin
              pend[k] = 1'b0;
            end else begin
              mask = (64'd1 << mw[k]) - 64'd1;
              line_m[k] = line_m[k] | ((64'(rdm[k]) & mask) << (got[k] * mw[k]));
              got[k]++;
            end
          end else if (flush[k]) begin
            drop[k] = 1'b1;
          end
        end else begin
          checkOutput("write_we", k, 64'(we_o[k]), 64'd1);
          checkOutput("write_data", k, wr_o[k], line_m[k]);
          checkOutput("write_fill_addr", k, 64'(fill_o[k]), 64'(base_m[k]));
          checkOutput("write_valid", k, 64'(iv_o[k]), 64'(!flush[k]));
          checkOutput("write_stall", k, 64'(stall_o[k]), 64'd0);
          checkOutput("write_re_icache", k, 64'(re_icache_o[k]), 64'd0);
          checkOutput("write_re_mem", k, 64'(re_o[k]), 64'd0);
          checkOutput("write_busy", k, 64'(busy_o[k]), 64'd1);
          checkOutput("write_instr", k, 64'(instr_o[k]), (line_m[k] >> (16 * off_m[k])) & 64'hFFFF);
          pend[k] = 1'b0;
        end
      end
    end
  end

  // Directed sequence with hand-computed literal expectations.
  initial begin
    rst = 1'b1;
    lat[0] = 3;
    lat[1] = 2;
    applyStimulus(0, 16'h0000, 1'b1, 1'b0, 64'h0);
    applyStimulus(1, 16'h0000, 1'b1, 1'b0, 64'h0);
    repeat (3) next_cycle();
    settle();
    checkOutput("lit_rst_stall", 0, 64'(stall_o[0]), 64'd1);
    checkOutput("lit_rst_re_mem", 0, 64'(re_o[0]), 64'd0);
    next_cycle();
    rst = 1'b0;

    $display("[TB] hit, default parameters");
    next_cycle();
    applyStimulus(0, 16'h0042, 1'b1, 1'b0, 64'h4444_3333_2222_1111);
    applyStimulus(1, 16'h0003, 1'b1, 1'b0, 64'h8888_7777_6666_5555);
    settle();
    checkOutput("lit_hit_instr", 0, 64'(instr_o[0]), 64'h3333);
    checkOutput("lit_hit_valid", 0, 64'(iv_o[0]), 64'd1);
    checkOutput("lit_hit_stall", 0, 64'(stall_o[0]), 64'd0);
    checkOutput("lit_hit_re_mem", 0, 64'(re_o[0]), 64'd0);
    checkOutput("lit_hit_instr", 1, 64'(instr_o[1]), 64'h8888);

    for (int i = 0; i < 4; i++) begin
      next_cycle();
      applyStimulus(0, 16'h0100 + 16'(i), 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    end

    $display("[TB] flush in IDLE");
    next_cycle();
    applyStimulus(0, 16'h0013, 1'b0, 1'b1, 64'h4444_3333_2222_1111);
    settle();
    checkOutput("lit_iflush_valid", 0, 64'(iv_o[0]), 64'd0);
    checkOutput("lit_iflush_stall", 0, 64'(stall_o[0]), 64'd0);
    checkOutput("lit_iflush_re_mem", 0, 64'(re_o[0]), 64'd0);
    next_cycle();
    applyStimulus(0, 16'h0013, 1'b1, 1'b0, 64'h4444_3333_2222_1111);
    settle();
    checkOutput("lit_iflush_busy", 0, 64'(busy_o[0]), 64'd0);

    $display("[TB] miss, L=3");
    next_cycle();
    hit[0] = 1'b0;
    settle();
    checkOutput("lit_miss_re_mem", 0, 64'(re_o[0]), 64'd1);
    checkOutput("lit_miss_addr0", 0, 64'(addr_o[0]), 64'h8);
    checkOutput("lit_miss_stall", 0, 64'(stall_o[0]), 64'd1);
    next_cycle();
    hit[0] = 1'b1;
    repeat (3) next_cycle();
    settle();
    checkOutput("lit_miss_addr1", 0, 64'(addr_o[0]), 64'h9);
    repeat (4) next_cycle();
    settle();
    checkOutput("lit_write_we", 0, 64'(we_o[0]), 64'd1);
    checkOutput("lit_write_data", 0, wr_o[0], 64'hDDDD_CCCC_BBBB_AAAA);
    checkOutput("lit_write_fill", 0, 64'(fill_o[0]), 64'h4);
    checkOutput("lit_write_instr", 0, 64'(instr_o[0]), 64'hDDDD);
    checkOutput("lit_write_valid", 0, 64'(iv_o[0]), 64'd1);
    next_cycle();
    settle();
    checkOutput("lit_after_busy", 0, 64'(busy_o[0]), 64'd0);
    checkOutput("lit_after_we", 0, 64'(we_o[0]), 64'd0);

    $display("[TB] flush during FILL");
    next_cycle();
    hit[0] = 1'b0;
    next_cycle();
    hit[0] = 1'b1;
    flush[0] = 1'b1;
    next_cycle();
    flush[0] = 1'b0;
    settle();
    checkOutput("lit_drain_re_mem", 0, 64'(re_o[0]), 64'd1);
    checkOutput("lit_drain_addr", 0, 64'(addr_o[0]), 64'h8);
    checkOutput("lit_drain_valid", 0, 64'(iv_o[0]), 64'd0);
    next_cycle();
    settle();
    checkOutput("lit_drain_addr_rdy", 0, 64'(addr_o[0]), 64'h8);
    next_cycle();
    settle();
    checkOutput("lit_drain_done_busy", 0, 64'(busy_o[0]), 64'd0);
    checkOutput("lit_drain_done_we", 0, 64'(we_o[0]), 64'd0);

    $display("[TB] flush with final rdy_mem");
    next_cycle();
    hit[0] = 1'b0;
    next_cycle();
    hit[0] = 1'b1;
    repeat (6) next_cycle();
    flush[0] = 1'b1;
    settle();
    checkOutput("lit_fflush_addr", 0, 64'(addr_o[0]), 64'h9);
    next_cycle();
    flush[0] = 1'b0;
    settle();
    checkOutput("lit_fflush_busy", 0, 64'(busy_o[0]), 64'd0);
    checkOutput("lit_fflush_we", 0, 64'(we_o[0]), 64'd0);

    $display("[TB] reset mid-refill");
    next_cycle();
    hit[0] = 1'b0;
    next_cycle();
    hit[0] = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b1;
    settle();
    checkOutput("lit_mrst_stall", 0, 64'(stall_o[0]), 64'd1);
    checkOutput("lit_mrst_re_mem", 0, 64'(re_o[0]), 64'd0);
    checkOutput("lit_mrst_we", 0, 64'(we_o[0]), 64'd0);
    next_cycle();
    rst = 1'b0;
    hit[0] = 1'b0;
    settle();
    checkOutput("lit_restart_addr", 0, 64'(addr_o[0]), 64'h8);
    checkOutput("lit_restart_busy", 0, 64'(busy_o[0]), 64'd0);
    next_cycle();
    hit[0] = 1'b1;
    repeat (7) next_cycle();
    settle();
    checkOutput("lit_restart_we", 0, 64'(we_o[0]), 64'd1);
    checkOutput("lit_restart_instr", 0, 64'(instr_o[0]), 64'hDDDD);

    $display("[TB] BEATS=4, MEM_W=16");
    next_cycle();
    spur[1] = 1'b1;
    settle();
    checkOutput("lit_spur_busy", 1, 64'(busy_o[1]), 64'd0);
    next_cycle();
    settle();
    checkOutput("lit_spur_busy_after", 1, 64'(busy_o[1]), 64'd0);
    next_cycle();
    applyStimulus(1, 16'h0016, 1'b0, 1'b0, 64'h0);
    settle();
    checkOutput("lit_b4_addr0", 1, 64'(addr_o[1]), 64'h14);
    next_cycle();
    hit[1] = 1'b1;
    repeat (2) next_cycle();
    settle();
    checkOutput("lit_b4_addr1", 1, 64'(addr_o[1]), 64'h15);
    repeat (3) next_cycle();
    settle();
    checkOutput("lit_b4_addr2", 1, 64'(addr_o[1]), 64'h16);
    repeat (3) next_cycle();
    settle();
    checkOutput("lit_b4_addr3", 1, 64'(addr_o[1]), 64'h17);
    repeat (3) next_cycle();
    settle();
    checkOutput("lit_b4_we", 1, 64'(we_o[1]), 64'd1);
    checkOutput("lit_b4_data", 1, wr_o[1], 64'hB017_B016_B015_B014);
    checkOutput("lit_b4_fill", 1, 64'(fill_o[1]), 64'h5);
    checkOutput("lit_b4_instr", 1, 64'(instr_o[1]), 64'hB016);
    next_cycle();
    settle();
    checkOutput("lit_b4_after_busy", 1, 64'(busy_o[1]), 64'd0);

    repeat (2) next_cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
